// File: rtl/comp2_alu_sequencer.sv
// rtl/comp2_alu_sequencer.sv - sequences an external two's-complement converter for signed ADD/SUB/NEG/ABS

module comp2_alu_sequencer #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] conv_a,
    input  logic [WIDTH-1:0] conv_result,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             result_valid,
    input  logic             result_ack
);

    typedef enum logic [1:0] {IDLE, CONV, EXEC, DONE} state_t;

    localparam logic [1:0]       OP_ADD  = 2'b00;
    localparam logic [1:0]       OP_SUB  = 2'b01;
    localparam logic [1:0]       OP_NEG  = 2'b10;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state, next_state;
    logic             accept;
    logic [WIDTH-1:0] a_reg, b_reg, neg_reg;
    logic [1:0]       op_reg;

    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] exec_result;
    logic             exec_carry, exec_overflow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state   = state;
        accept       = 1'b0;
        busy         = 1'b1;
        result_valid = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    accept     = 1'b1;
                    next_state = (op == OP_ADD) ? EXEC : CONV;
                end
            end
            CONV: next_state = EXEC;
            EXEC: next_state = DONE;
            DONE: begin
                result_valid = 1'b1;
                if (result_ack) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // ADD uses B directly; every other op works from the negated operand.
    always_comb begin
        addend        = (op_reg == OP_ADD) ? b_reg : neg_reg;
        sum           = {1'b0, a_reg} + {1'b0, addend};
        exec_result   = sum[WIDTH-1:0];
        exec_carry    = sum[WIDTH];
        exec_overflow = (a_reg[WIDTH-1] == addend[WIDTH-1]) &&
                        (sum[WIDTH-1] != a_reg[WIDTH-1]);
        if (op_reg[1]) begin
            exec_carry    = 1'b0;
            exec_overflow = (a_reg == MIN_NEG);
            if (op_reg == OP_NEG || a_reg[WIDTH-1]) exec_result = neg_reg;
            else                                    exec_result = a_reg;
        end
    end

    // conv_a is loaded at accept so it is already stable throughout CONV.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            op_reg   <= '0;
            neg_reg  <= '0;
            conv_a   <= '0;
            result   <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                a_reg  <= a_in;
                b_reg  <= b_in;
                op_reg <= op;
                if (op != OP_ADD) conv_a <= (op == OP_SUB) ? b_in : a_in;
            end
            if (state == CONV) neg_reg <= conv_result;
            if (state == EXEC) begin
                result   <= exec_result;
                carry    <= exec_carry;
                overflow <= exec_overflow;
            end
        end
    end

endmodule

// File: tb/tb_comp2_alu_sequencer.sv
// tb/tb_comp2_alu_sequencer.sv - directed self-checking bench for comp2_alu_sequencer

module tb_comp2_alu_sequencer;

    localparam int WIDTH = 6;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [1:0]       op = 2'b00;
    logic [WIDTH-1:0] a_in = '0;
    logic [WIDTH-1:0] b_in = '0;
    logic [WIDTH-1:0] conv_a;
    logic [WIDTH-1:0] conv_result;
    logic             busy;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             overflow;
    logic             result_valid;
    logic             result_ack = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // External converter: pure combinational negation.
    assign conv_result = -conv_a;

    comp2_alu_sequencer #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .op           (op),
        .a_in         (a_in),
        .b_in         (b_in),
        .conv_a       (conv_a),
        .conv_result  (conv_result),
        .busy         (busy),
        .result       (result),
        .carry        (carry),
        .overflow     (overflow),
        .result_valid (result_valid),
        .result_ack   (result_ack)
    );

    // Drive one request; returns #1 after the accept edge with operands scrambled.
    task automatic issue(input logic [1:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        @(negedge clk);
        op = o; a_in = a; b_in = b; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a_in  = 6'h2a;
        b_in  = 6'h15;
        op    = 2'b11;
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!result_valid && cycles < 10) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic do_ack();
        @(negedge clk);
        result_ack = 1'b1;
        @(posedge clk);
        #1;
        result_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, result_valid, result, carry, overflow, conv_a} !== '0) begin
            errors++;
            $display("FAIL reset_state: busy=%b valid=%b result=%b carry=%b ovf=%b conv_a=%b, required all 0",
                     busy, result_valid, result, carry, overflow, conv_a);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add();
        logic [WIDTH-1:0] va [3] = '{6'd5, 6'd31, 6'b111111};
        logic [WIDTH-1:0] vb [3] = '{6'd3, 6'd1,  6'b111111};
        logic [WIDTH-1:0] er [3] = '{6'd8, 6'b100000, 6'b111110};
        logic             ec [3] = '{1'b0, 1'b0, 1'b1};
        logic             eo [3] = '{1'b0, 1'b1, 1'b0};
        int cyc;
        for (int i = 0; i < 3; i++) begin
            issue(2'b00, va[i], vb[i]);
            wait_valid(cyc);
            checks++;
            if (cyc !== 1) begin
                errors++;
                $display("FAIL add_latency[%0d]: edges after accept=%0d, required 1", i, cyc);
            end
            checks++;
            if ({result, carry, overflow} !== {er[i], ec[i], eo[i]}) begin
                errors++;
                $display("FAIL add_result[%0d]: result=%b carry=%b ovf=%b, required %b %b %b",
                         i, result, carry, overflow, er[i], ec[i], eo[i]);
            end
            do_ack();
            checks++;
            if (result_valid !== 1'b0 || busy !== 1'b0 || result !== er[i]) begin
                errors++;
                $display("FAIL add_ack[%0d]: valid=%b busy=%b result=%b, required 0 0 %b",
                         i, result_valid, busy, result, er[i]);
            end
        end
    endtask

    task automatic test_conv_ops();
        logic [1:0]       vo [5] = '{2'b01, 2'b01, 2'b10, 2'b11, 2'b11};
        logic [WIDTH-1:0] va [5] = '{6'd5, 6'd31, 6'b100000, 6'b111001, 6'd9};
        logic [WIDTH-1:0] vb [5] = '{6'd3, 6'b111111, 6'd0, 6'd0, 6'd0};
        logic [WIDTH-1:0] ea [5] = '{6'd3, 6'b111111, 6'b100000, 6'b111001, 6'd9};
        logic [WIDTH-1:0] er [5] = '{6'd2, 6'b100000, 6'b100000, 6'd7, 6'd9};
        logic             ec [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic             eo [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        int cyc;
        for (int i = 0; i < 5; i++) begin
            issue(vo[i], va[i], vb[i]);
            checks++;
            if (conv_a !== ea[i] || busy !== 1'b1) begin
                errors++;
                $display("FAIL conv_operand[%0d]: conv_a=%b busy=%b, required %b 1", i, conv_a, busy, ea[i]);
            end
            wait_valid(cyc);
            checks++;
            if (cyc !== 2) begin
                errors++;
                $display("FAIL conv_latency[%0d]: edges after accept=%0d, required 2", i, cyc);
            end
            checks++;
            if ({result, carry, overflow} !== {er[i], ec[i], eo[i]}) begin
                errors++;
                $display("FAIL conv_result[%0d]: result=%b carry=%b ovf=%b, required %b %b %b",
                         i, result, carry, overflow, er[i], ec[i], eo[i]);
            end
            do_ack();
            checks++;
            if (conv_a !== ea[i]) begin
                errors++;
                $display("FAIL conv_a_hold[%0d]: conv_a=%b, required %b", i, conv_a, ea[i]);
            end
        end
    endtask

    task automatic test_hold_and_ack();
        int cyc;
        int bad = 0;
        issue(2'b00, 6'd5, 6'd3);
        // Acknowledge during EXEC must be ignored.
        @(negedge clk);
        result_ack = 1'b1;
        @(posedge clk);
        #1;
        result_ack = 1'b0;
        wait_valid(cyc);
        checks++;
        if (result_valid !== 1'b1 || result !== 6'd8) begin
            errors++;
            $display("FAIL early_ack: valid=%b result=%b, required 1 001000", result_valid, result);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start = 1'b1; op = 2'b10; a_in = 6'd1;
            @(posedge clk);
            #1;
            if (result_valid !== 1'b1 || result !== 6'd8 || busy !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold_in_done: %0d unstable cycles, required 0", bad);
        end
        @(negedge clk);
        start = 1'b1; result_ack = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL ack_with_start: busy=%b valid=%b, required 0 0", busy, result_valid);
        end
        start = 1'b0; result_ack = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        int cyc;
        int pulses = 0;
        issue(2'b01, 6'd5, 6'd3);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, result_valid, result, carry, overflow, conv_a} !== '0) begin
            errors++;
            $display("FAIL reset_mid_op: busy=%b valid=%b result=%b carry=%b ovf=%b conv_a=%b, required all 0",
                     busy, result_valid, result, carry, overflow, conv_a);
        end
        repeat (3) begin
            @(posedge clk);
            #1;
            if (result_valid) pulses++;
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (result_valid || busy) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL reset_no_valid: %0d active cycles, required 0", pulses);
        end
        issue(2'b00, 6'd1, 6'd1);
        wait_valid(cyc);
        checks++;
        if (result_valid !== 1'b1 || result !== 6'd2 || carry !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL add_after_reset: valid=%b result=%b carry=%b ovf=%b, required 1 000010 0 0",
                     result_valid, result, carry, overflow);
        end
        do_ack();
    endtask

    initial begin
        test_reset();
        test_add();
        test_conv_ops();
        test_hold_and_ack();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
